alu4_cmd_driver: RTL and testbench
==================================

# alu4_cmd_driver

Sequential command front-end for the 8-function 4-bit ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's `sig` / `operand1` / `operand2` inputs from registers. It samples the ALU's `result` / `cout` and returns a tagged, error-checked response over a second valid/ready handshake. It sits between any command initiator (test sequencer, microcode unit) and the combinational ALU.

## Interface
Parameters:
- `TAG_W`, default 4: width of the response sequence tag.
- `ERR_CNT_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  initiator has a command.
- `cmd_ready`  out  1  driver can accept a command.
- `cmd_op`  in  3  opcode: 000 OP1, 001 ADD, 010 SUB, 011 DIV, 100 REM, 101 LSH, 110 RSH, 111 COM.
- `cmd_a`  in  4  operand A.
- `cmd_b`  in  4  operand B.
- `alu_sig`  out  3  to ALU `sig`, registered.
- `alu_op1`  out  4  to ALU `operand1`, registered.
- `alu_op2`  out  4  to ALU `operand2`, registered.
- `alu_result`  in  5  from ALU `result`.
- `alu_cout`  in  1  from ALU `cout`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  5  captured result.
- `rsp_cout`  out  1  masked carry/borrow.
- `rsp_err`  out  1  command rejected (divide by zero).
- `rsp_tag`  out  TAG_W  sequence number of this response.
- `err_count`  out  ERR_CNT_W  saturating count of errored commands.

## Operation
- The FSM has four states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`: register `cmd_op`/`cmd_a`/`cmd_b` into `alu_sig`/`alu_op1`/`alu_op2`.
  - If op is DIV or REM and `cmd_b` == 0: load `rsp_result` = 0, `rsp_cout` = 0, `rsp_err` = 1, increment `err_count` (saturating at all-ones), go to RESP.
  - Otherwise go to EXEC.
- EXEC: one settle cycle for the combinational ALU; go to CAPT unconditionally.
- CAPT:
  - Load `rsp_result` = `alu_result` and `rsp_err` = 0.
  - Load `rsp_cout` = `alu_cout` only for ADD/SUB; 0 for all other ops. The ALU holds a stale `cout` on non-arithmetic ops, so masking is mandatory.
  - Go to RESP.
- RESP:
  - `rsp_valid` = 1; all `rsp_*` and `alu_*` outputs stay stable.
  - On `rsp_ready`: `rsp_tag` increments (mod 2^TAG_W, wraps from all-ones to 0), go to IDLE.
- `cmd_ready` is registered: it is 1 only in IDLE and 0 in EXEC/CAPT/RESP. At most one command is outstanding.
- `rsp_tag` reflects the count of completed responses before the current one. The first response after reset carries tag 0.
- Result width: the ALU is 5-bit. SUB wraps as 5-bit two's complement; the driver never modifies `alu_result`.
- All 8 opcodes are legal. Divide by zero is the only error condition.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - state IDLE;
  - `cmd_ready` = 0, `rsp_valid` = 0;
  - `alu_sig`/`alu_op1`/`alu_op2` = 0;
  - `rsp_result` = 0, `rsp_cout` = 0, `rsp_err` = 0;
  - `rsp_tag` = 0, `err_count` = 0.
- `cmd_ready` rises on the first `clk` edge after `rst_n` deasserts.
- Normal command accepted at edge N: `alu_*` valid after N; `rsp_valid` rises after edge N+2; IDLE reached at the edge where `rsp_ready` is seen. Minimum 4 cycles per command (ready seen on the same cycle `rsp_valid` rises).
- Error command accepted at edge N: `rsp_valid` rises after edge N (no EXEC/CAPT). `err_count` updates at edge N.
- Back-pressure: with `rsp_ready` held low, RESP persists indefinitely with stable outputs. `cmd_valid` is ignored while `cmd_ready` = 0.
- Reset mid-operation (any state): the in-flight command is discarded, no response is produced, and all outputs go to reset values immediately.
- `err_count` at all-ones stays at all-ones on further errors; `rsp_tag` still increments.

## Test plan
- Reset release, then ADD a=9 b=8 -> `rsp_valid` after edge N+2, `rsp_result` = 5'b10001, `rsp_cout` = 1, `rsp_err` = 0, `rsp_tag` = 0.
- SUB a=3 b=5, then LSH a=12 with a stubbed ALU holding `cout` = 1 -> SUB returns result 5'b11110 with cout 1; LSH returns result 5'b11000 with `rsp_cout` = 0 (masking check); tags 0 then 1.
- DIV a=7 b=0 -> `rsp_valid` after edge N, `rsp_err` = 1, result 0, `err_count` = 1, `alu_sig` = 011. Follow with REM a=7 b=3 -> result 1, `rsp_err` = 0.
- Hold `rsp_ready` low for 10 cycles during a COM a=6 b=2 response -> `rsp_valid` = 1 and result 5'b00001 stable for all 10 cycles, `cmd_ready` = 0, an extra `cmd_valid` is ignored. Tag increments only on the release cycle.
- 17 back-to-back commands with TAG_W = 4 -> tags 0..15 then 0. 260 DIV-by-zero commands -> `err_count` saturates at 255.
- Assert `rst_n` low during EXEC of RSH a=10 -> all outputs 0 asynchronously and no response. After release, OP1 a=5 returns result 5 with tag 0.

Source files
------------

// File: rtl/alu4_cmd_driver_if.sv
// Bus bundle between a command initiator, the command driver and the 4-bit ALU.
// The slave modport is the driver's view; master is the initiator/ALU-side view.
interface alu4_cmd_driver_if #(
  parameter int TAG_W     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [3:0]           cmd_a;
  logic [3:0]           cmd_b;

  logic [2:0]           alu_sig;
  logic [3:0]           alu_op1;
  logic [3:0]           alu_op2;
  logic [4:0]           alu_result;
  logic                 alu_cout;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [4:0]           rsp_result;
  logic                 rsp_cout;
  logic                 rsp_err;
  logic [TAG_W-1:0]     rsp_tag;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_result, alu_cout,
    input  rsp_ready,
    output cmd_ready,
    output alu_sig, alu_op1, alu_op2,
    output rsp_valid, rsp_result, rsp_cout, rsp_err, rsp_tag, err_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_result, alu_cout,
    output rsp_ready,
    input  cmd_ready,
    input  alu_sig, alu_op1, alu_op2,
    input  rsp_valid, rsp_result, rsp_cout, rsp_err, rsp_tag, err_count
  );
endinterface

// File: rtl/alu4_cmd_driver.sv
// Command front-end for the 8-function 4-bit ALU: registers operands, waits for the
// combinational ALU to settle, captures its result and returns a tagged response.
module alu4_cmd_driver #(
  parameter int TAG_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu4_cmd_driver_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] OP_OP1 = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_REM = 3'b100;
  localparam logic [2:0] OP_LSH = 3'b101;
  localparam logic [2:0] OP_RSH = 3'b110;
  localparam logic [2:0] OP_COM = 3'b111;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 r_cmd_ready;
  logic                 r_rsp_valid;
  logic [2:0]           r_alu_sig;
  logic [3:0]           r_alu_op1;
  logic [3:0]           r_alu_op2;
  logic [4:0]           r_rsp_result;
  logic                 r_rsp_cout;
  logic                 r_rsp_err;
  logic [TAG_W-1:0]     r_rsp_tag;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_accept;
  logic                 w_div_op;
  logic                 w_div_zero;
  logic                 w_rsp_done;
  logic                 w_arith;
  logic                 w_err_sat;

  assign w_accept   = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;
  assign w_div_op   = (bus.cmd_op == OP_DIV) || (bus.cmd_op == OP_REM);
  assign w_div_zero = w_div_op && (bus.cmd_b == 4'd0);
  assign w_rsp_done = (r_state == S_RESP) && bus.rsp_ready;
  // Only ADD/SUB produce a meaningful carry; the ALU leaves cout stale otherwise.
  assign w_arith    = (r_alu_sig == OP_ADD) || (r_alu_sig == OP_SUB);
  assign w_err_sat  = &r_err_count;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_div_zero ? S_RESP : S_EXEC;
        end
      end
      S_EXEC:  w_state_next = S_CAPT;
      S_CAPT:  w_state_next = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state's decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cmd_ready <= (w_state_next == S_IDLE);
      r_rsp_valid <= (w_state_next == S_RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_sig <= OP_OP1;
      r_alu_op1 <= 4'd0;
      r_alu_op2 <= 4'd0;
    end else if (w_accept) begin
      r_alu_sig <= bus.cmd_op;
      r_alu_op1 <= bus.cmd_a;
      r_alu_op2 <= bus.cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= 5'd0;
      r_rsp_cout   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (w_accept && w_div_zero) begin
      r_rsp_result <= 5'd0;
      r_rsp_cout   <= 1'b0;
      r_rsp_err    <= 1'b1;
    end else if (r_state == S_CAPT) begin
      r_rsp_result <= bus.alu_result;
      r_rsp_cout   <= w_arith ? bus.alu_cout : 1'b0;
      r_rsp_err    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_tag <= '0;
    end else if (w_rsp_done) begin
      r_rsp_tag <= r_rsp_tag + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_accept && w_div_zero && !w_err_sat) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.alu_sig    = r_alu_sig;
  assign bus.alu_op1    = r_alu_op1;
  assign bus.alu_op2    = r_alu_op2;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_cout   = r_rsp_cout;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_alu4_cmd_driver.sv
// Self-checking bench: stub ALU with a stale carry, random command stream checked
// against an arithmetic reference model plus directed reset/back-pressure cases.
module tb_alu4_cmd_driver;

  localparam int TAG_W     = 4;
  localparam int ERR_CNT_W = 8;
  localparam int TAG_MOD   = 1 << TAG_W;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic stale_cout;
  logic [4:0] stub_res;
  logic       stub_co;

  int n_chk;
  int n_err;
  int tag_m;
  int err_m;

  alu4_cmd_driver_if #(.TAG_W(TAG_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

  alu4_cmd_driver #(.TAG_W(TAG_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: garbage on divide by zero and a stale carry on non-arithmetic ops.
  always_comb begin
    stub_res = 5'd0;
    stub_co  = stale_cout;
    case (bus.alu_sig)
      3'd0: stub_res = {1'b0, bus.alu_op1};
      3'd1: begin
        stub_res = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
        stub_co  = stub_res[4];
      end
      3'd2: begin
        stub_res = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
        stub_co  = stub_res[4];
      end
      3'd3: stub_res = (bus.alu_op2 == 4'd0) ? 5'h1f : {1'b0, bus.alu_op1 / bus.alu_op2};
      3'd4: stub_res = (bus.alu_op2 == 4'd0) ? 5'h1e : {1'b0, bus.alu_op1 % bus.alu_op2};
      3'd5: stub_res = {bus.alu_op1, 1'b0};
      3'd6: stub_res = {2'b00, bus.alu_op1[3:1]};
      default: stub_res = {4'd0, (bus.alu_op1 > bus.alu_op2)};
    endcase
  end
  assign bus.alu_result = stub_res;
  assign bus.alu_cout   = stub_co;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected response computed from the opcode rules with integer arithmetic.
  function automatic void ref_model(input int op, input int a, input int b,
                                    output int res, output int co, output int er);
    res = 0; co = 0; er = 0;
    case (op)
      0: res = a;
      1: begin res = a + b; co = (a + b > 15) ? 1 : 0; end
      2: begin res = (a - b + 32) % 32; co = (a < b) ? 1 : 0; end
      3: if (b == 0) er = 1; else res = a / b;
      4: if (b == 0) er = 1; else res = a % b;
      5: res = (a * 2) % 32;
      6: res = a / 2;
      default: res = (a > b) ? 1 : 0;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"},  int'(bus.cmd_ready), 0);
    chk({pfx, "_rsp_valid"},  int'(bus.rsp_valid), 0);
    chk({pfx, "_alu_sig"},    int'(bus.alu_sig), 0);
    chk({pfx, "_alu_op1"},    int'(bus.alu_op1), 0);
    chk({pfx, "_alu_op2"},    int'(bus.alu_op2), 0);
    chk({pfx, "_rsp_result"}, int'(bus.rsp_result), 0);
    chk({pfx, "_rsp_cout"},   int'(bus.rsp_cout), 0);
    chk({pfx, "_rsp_err"},    int'(bus.rsp_err), 0);
    chk({pfx, "_rsp_tag"},    int'(bus.rsp_tag), 0);
    chk({pfx, "_err_count"},  int'(bus.err_count), 0);
  endtask

  // One full command/response transaction; hold = cycles rsp_ready stays low,
  // poke = drive a stray command while the driver is busy.
  task automatic do_cmd(input int op, input int a, input int b, input int hold, input bit poke);
    int res, co, er, k;
    ref_model(op, a, b, res, co, er);
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_a     = 4'(a);
    bus.cmd_b     = 4'(b);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_a     = 4'($urandom);
    bus.cmd_b     = 4'($urandom);
    if (er != 0) err_m = (err_m < ERR_MAX) ? err_m + 1 : ERR_MAX;
    chk("alu_sig",  int'(bus.alu_sig), op);
    chk("alu_op1",  int'(bus.alu_op1), a);
    chk("alu_op2",  int'(bus.alu_op2), b);
    chk("busy_ready", int'(bus.cmd_ready), 0);
    k = 0;
    while (!bus.rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_latency", k, (er != 0) ? 0 : 2);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid",  int'(bus.rsp_valid), 1);
      chk("rsp_result", int'(bus.rsp_result), res);
      chk("rsp_cout",   int'(bus.rsp_cout), co);
      chk("rsp_err",    int'(bus.rsp_err), er);
      chk("rsp_tag",    int'(bus.rsp_tag), tag_m % TAG_MOD);
      chk("err_count",  int'(bus.err_count), err_m);
      chk("resp_ready_low", int'(bus.cmd_ready), 0);
      chk("resp_alu_sig", int'(bus.alu_sig), op);
      if (h < hold) begin
        if (poke) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_op    = 3'(op ^ 7);
          bus.cmd_a     = 4'(a ^ 15);
          bus.cmd_b     = 4'd0;
        end
        @(negedge clk);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    $display("txn op=%0d a=%0d b=%0d -> result=%0d cout=%0d err=%0d tag=%0d err_count=%0d",
             op, a, b, bus.rsp_result, bus.rsp_cout, bus.rsp_err, tag_m % TAG_MOD, bus.err_count);
    tag_m++;
    chk("post_rsp_valid", int'(bus.rsp_valid), 0);
    chk("post_rsp_tag",   int'(bus.rsp_tag), tag_m % TAG_MOD);
    chk("post_cmd_ready", int'(bus.cmd_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; tag_m = 0; err_m = 0;
    rst_n = 1'b0;
    stale_cout = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_a = 4'd0;
    bus.cmd_b = 4'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", int'(bus.cmd_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", int'(bus.cmd_ready), 1);

    do_cmd(1, 9, 8, 0, 1'b0);
    stale_cout = 1'b1;
    do_cmd(2, 3, 5, 0, 1'b0);
    do_cmd(5, 12, 0, 0, 1'b0);
    do_cmd(3, 7, 0, 0, 1'b0);
    do_cmd(4, 7, 3, 0, 1'b0);
    do_cmd(7, 6, 2, 10, 1'b1);

    for (int i = 0; i < 17; i++) begin
      stale_cout = 1'($urandom);
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'($urandom));
    end
    for (int i = 0; i < 260; i++) begin
      do_cmd(($urandom_range(0, 1) == 0) ? 3 : 4, int'($urandom_range(0, 15)), 0, 0, 1'b0);
    end
    chk("err_saturated", int'(bus.err_count), ERR_MAX);

    // Reset arrives while the RSH command sits in EXEC.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd6;
    bus.cmd_a = 4'd10;
    bus.cmd_b = 4'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("midop_alu_sig", int'(bus.alu_sig), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    chk("reset_no_rsp", int'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    tag_m = 0;
    err_m = 0;
    @(negedge clk);
    chk("rerelease_ready", int'(bus.cmd_ready), 1);
    chk("rerelease_no_rsp", int'(bus.rsp_valid), 0);
    stale_cout = 1'b1;
    do_cmd(0, 5, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
